reg_snapshot_streamer: RTL

//   Cycle-triggered register-file snapshot unit: counts enabled clocks, captures NUM_REGS

---
 rtl/reg_snapshot_streamer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_snapshot_streamer.sv
// Cycle-triggered register-file snapshot unit: counts enabled clocks, captures the
// register file on the programmed cycle and streams it out over valid/ready.
module reg_snapshot_streamer #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 13,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 16,
    parameter int PERIODIC = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [CNT_W-1:0]             trig_cycle_i,
    input  logic [NUM_REGS*DATA_W-1:0]   regs_flat_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [IDX_W-1:0]             out_idx_o,
    output logic [DATA_W-1:0]            out_data_o,
    output logic                         out_last_o,
    output logic [CNT_W-1:0]             cycle_cnt_o,
    output logic                         done_o,
    output logic                         overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_COUNT,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_REGS*DATA_W-1:0]   snap_q, snap_d;
    logic                         overrun_q, overrun_d;

    logic hit;
    logic handshake;
    logic final_hs;

    // Compare one bit wider so a saturated counter can never alias onto a trigger value.
    always_comb begin
        hit       = en_i && (trig_cycle_i != '0) &&
                    ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1) == (CNT_W+1)'(trig_cycle_i));
        handshake = (state_q == ST_STREAM) && out_ready_i;
        final_hs  = handshake && (idx_q == LAST_IDX);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            if ((PERIODIC != 0) && hit) begin
                cnt_d = '0;
            end else if ((PERIODIC != 0) || (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_COUNT: begin
                if (hit) begin
                    snap_d  = regs_flat_i;
                    idx_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (hit && !final_hs) begin
                    overrun_d = 1'b1;
                end
                if (final_hs) begin
                    idx_d = '0;
                    if (PERIODIC == 0) begin
                        state_d = ST_DONE;
                    end else if (hit) begin
                        // A capture landing on the closing handshake starts the next stream seamlessly.
                        snap_d  = regs_flat_i;
                        state_d = ST_STREAM;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else if (handshake) begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_COUNT;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        out_valid_o = (state_q == ST_STREAM);
        out_idx_o   = idx_q;
        out_data_o  = out_valid_o ? snap_q[int'(idx_q)*DATA_W +: DATA_W] : '0;
        out_last_o  = out_valid_o && (idx_q == LAST_IDX);
        cycle_cnt_o = cnt_q;
        done_o      = (state_q == ST_DONE);
        overrun_o   = overrun_q;
    end

endmodule
